// File: rtl/nonce_collector.sv
// Round-robin nonce collector: latches per-slave results, queues them in a FIFO, drains to serial_transmit.
// Optional NONCE_DEDUP_EN: discard a granted nonce equal to the last pushed word.
module nonce_collector #(
    parameter int unsigned SLAVES    = 2,
    parameter int unsigned FIFO_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SLAVES*32-1:0]   slave_nonces,
    input  logic [SLAVES-1:0]      new_nonces,
    input  logic                   serial_busy,
    output logic                   serial_send,
    output logic [31:0]            golden_nonce,
    output logic [FIFO_LOG2:0]     fifo_level,
    output logic [15:0]            drop_count
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned LVL_W = FIFO_LOG2 + 1;
    localparam int unsigned RR_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, HOLD1, HOLD2} state_t;

    state_t               state, state_nxt;
    logic [31:0]          hold [SLAVES];
    logic [SLAVES-1:0]    pend;
    logic [RR_W-1:0]      rr;
    logic [31:0]          mem [DEPTH];
    logic [FIFO_LOG2-1:0] wptr, rptr;

    logic                 req_any, grant, push, discard_c, pop_c, send_nxt;
    logic [RR_W-1:0]      gnt_idx, rr_nxt;
    int unsigned          arb_idx, drop_n;
    logic [LVL_W-1:0]     level_nxt;
    logic [16:0]          drop_sum;
    logic [15:0]          drop_nxt;

    // Round-robin search of pending slaves starting at rr
    always_comb begin
        req_any = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        for (int k = 0; k < int'(SLAVES); k++) begin
            arb_idx = int'(rr) + k;
            if (arb_idx >= SLAVES) arb_idx = arb_idx - SLAVES;
            if (!req_any && pend[arb_idx]) begin
                req_any = 1'b1;
                gnt_idx = RR_W'(arb_idx);
            end
        end
    end

    assign rr_nxt = (gnt_idx == RR_W'(SLAVES - 1)) ? '0 : gnt_idx + RR_W'(1);
    assign grant  = req_any && ((fifo_level < LVL_W'(DEPTH)) || pop_c);
    assign push   = grant && !discard_c;

`ifdef NONCE_DEDUP_EN
    logic [31:0] last_push;
    logic        last_valid;

    assign discard_c = last_valid && (hold[gnt_idx] == last_push);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_push  <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last_push  <= hold[gnt_idx];
            last_valid <= 1'b1;
        end
    end
`else
    assign discard_c = 1'b0;
`endif

    // Overwrites: a new pulse on a pending slave that is not being granted this cycle
    always_comb begin
        drop_n = 0;
        for (int i = 0; i < int'(SLAVES); i++) begin
            if (new_nonces[i] && pend[i] && !(grant && (gnt_idx == RR_W'(i))))
                drop_n = drop_n + 1;
        end
        drop_sum = {1'b0, drop_count} + 17'(drop_n);
        drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        level_nxt = fifo_level;
        case ({push, pop_c})
            2'b10:   level_nxt = fifo_level + LVL_W'(1);
            2'b01:   level_nxt = fifo_level - LVL_W'(1);
            default: level_nxt = fifo_level;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(SLAVES); i++) begin
            if (new_nonces[i]) hold[i] <= slave_nonces[i*32 +: 32];
        end
        if (push) mem[wptr] <= hold[gnt_idx];
    end

    // A new pulse wins over the grant clear, so the fresh value stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            rr         <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            for (int i = 0; i < int'(SLAVES); i++) begin
                if (new_nonces[i])
                    pend[i] <= 1'b1;
                else if (grant && (gnt_idx == RR_W'(i)))
                    pend[i] <= 1'b0;
            end
            if (grant) rr <= rr_nxt;
            if (push)  wptr <= wptr + FIFO_LOG2'(1);
            if (pop_c) rptr <= rptr + FIFO_LOG2'(1);
            fifo_level <= level_nxt;
            drop_count <= drop_nxt;
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Drain FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop_c) state_nxt = SEND;
            SEND:    state_nxt = HOLD1;
            HOLD1:   state_nxt = HOLD2;
            HOLD2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        pop_c    = 1'b0;
        send_nxt = 1'b0;
        if (state == IDLE && fifo_level != '0 && !serial_busy) begin
            pop_c    = 1'b1;
            send_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            serial_send  <= 1'b0;
            golden_nonce <= '0;
        end else begin
            serial_send <= send_nxt;
            if (pop_c) golden_nonce <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_nonce_collector.sv
// Scoreboard bench for nonce_collector: stimulus pushes expected words, a monitor checks each serial_send.
module tb_nonce_collector;

    logic        clk;
    logic        reset;
    logic [63:0] slave_nonces;
    logic [1:0]  new_nonces;
    logic        serial_busy;
    logic        serial_send;
    logic [31:0] golden_nonce;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int send_count = 0;
    logic [31:0] exp_q[$];

    nonce_collector #(.SLAVES(2), .FIFO_LOG2(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .slave_nonces (slave_nonces),
        .new_nonces   (new_nonces),
        .serial_busy  (serial_busy),
        .serial_send  (serial_send),
        .golden_nonce (golden_nonce),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic pulse(input logic [1:0] mask, input logic [31:0] n0, input logic [31:0] n1);
        new_nonces   = mask;
        slave_nonces = {n1, n0};
        tick();
        new_nonces   = 2'b00;
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || fifo_level != 4'd0) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d words still expected, fifo_level=%0d", exp_q.size(), fifo_level);
        end
        repeat (6) tick();
    endtask

    // Monitor: every send pulse must match the oldest expected word
    always @(negedge clk) begin
        logic [31:0] want;
        if (!reset && serial_send) begin
            send_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_send: golden_nonce=%h with nothing expected", golden_nonce);
            end else begin
                want = exp_q.pop_front();
                if (golden_nonce !== want) begin
                    errors++;
                    $display("FAIL send_order: got %h expected %h", golden_nonce, want);
                end
            end
        end
    end

    initial begin
        int sends_before;
        int exp_sends;
        logic [31:0] v;

        reset        = 1'b1;
        new_nonces   = 2'b00;
        slave_nonces = '0;
        serial_busy  = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_send",   32'(serial_send), 32'd0);
        chk("reset_golden", golden_nonce,     32'd0);
        chk("reset_level",  32'(fifo_level),  32'd0);
        chk("reset_drop",   32'(drop_count),  32'd0);

        // Single nonce latency
        tick();
        exp_q.push_back(32'hDEADBEEF);
        pulse(2'b01, 32'hDEADBEEF, 32'h0);
        tick();
        @(negedge clk);
        chk("lat_level_c2", 32'(fifo_level),  32'd1);
        chk("lat_send_c2",  32'(serial_send), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_send_c3",  32'(serial_send), 32'd1);
        chk("lat_level_c3", 32'(fifo_level),  32'd0);
        chk("lat_golden",   golden_nonce,     32'hDEADBEEF);
        wait_drain();

        // Simultaneous pulses, rr=0 then rr=1
        do_reset();
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        pulse(2'b11, 32'h11111111, 32'h22222222);
        wait_drain();
        exp_q.push_back(32'h33333333);
        pulse(2'b01, 32'h33333333, 32'h0);
        wait_drain();
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h11111111);
        pulse(2'b11, 32'h11111111, 32'h22222222);
        wait_drain();

        // Back-pressure: 9 nonces into an 8-deep FIFO
        do_reset();
        serial_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            v = 32'h100 + 32'(i);
            exp_q.push_back(v);
            if (i % 2 == 0) pulse(2'b01, v, 32'h0);
            else            pulse(2'b10, 32'h0, v);
        end
        repeat (3) tick();
        @(negedge clk);
        chk("bp_level_full", 32'(fifo_level), 32'd8);
        chk("bp_drop",       32'(drop_count), 32'd0);
        tick();
        serial_busy = 1'b0;
        wait_drain();

        // Overwrite while FIFO is full
        do_reset();
        serial_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 32'h200 + 32'(i);
            exp_q.push_back(v);
            if (i % 2 == 0) pulse(2'b01, v, 32'h0);
            else            pulse(2'b10, 32'h0, v);
        end
        pulse(2'b01, 32'hA, 32'h0);
        pulse(2'b01, 32'hB, 32'h0);
        exp_q.push_back(32'hB);
        repeat (2) tick();
        @(negedge clk);
        chk("ow_drop",  32'(drop_count), 32'd1);
        chk("ow_level", 32'(fifo_level), 32'd8);
        tick();
        serial_busy = 1'b0;
        wait_drain();
        chk("ow_drop_after", 32'(drop_count), 32'd1);
        chk("ow_last_word",  golden_nonce,    32'hB);

        // Reset mid-drain with five words queued
        serial_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v = 32'h300 + 32'(i);
            pulse(2'(1 << (i % 2)), v, v);
        end
        repeat (3) tick();
        @(negedge clk);
        chk("rst_level_before", 32'(fifo_level), 32'd5);
        tick();
        do_reset();
        @(negedge clk);
        chk("rst_level",  32'(fifo_level),  32'd0);
        chk("rst_send",   32'(serial_send), 32'd0);
        chk("rst_golden", golden_nonce,     32'd0);
        chk("rst_drop",   32'(drop_count),  32'd0);
        sends_before = send_count;
        tick();
        serial_busy = 1'b0;
        repeat (20) tick();
        chk("rst_no_sends", 32'(send_count), 32'(sends_before));

        // Duplicate nonce from both slaves
        do_reset();
        sends_before = send_count;
        exp_q.push_back(32'hCAFEF00D);
        exp_sends = 1;
`ifndef NONCE_DEDUP_EN
        exp_q.push_back(32'hCAFEF00D);
        exp_sends = 2;
`endif
        pulse(2'b11, 32'hCAFEF00D, 32'hCAFEF00D);
        wait_drain();
        chk("dup_sends", 32'(send_count - sends_before), 32'(exp_sends));
        chk("dup_drop",  32'(drop_count), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_collector.md
# nonce_collector

Parameterised result collector between the per-slave `slave_receive` input buffers and the uplink `serial_transmit` in the cluster hub. It latches every nonce reported by any slave and arbitrates round-robin among pending slaves. Accepted nonces are queued in a FIFO and drained one word at a time through the serial transmitter's send/busy handshake. It replaces the hub's fixed two-slave priority logic and works for any `SLAVES`.

## Interface
- `SLAVES`, 2: number of slave result ports (local miners plus external ports); ≥1.
- `FIFO_LOG2`, 3: FIFO depth is 2^FIFO_LOG2 words of 32 bits.
- `clk` input 1: hub clock (hash_clk); all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `slave_nonces` input SLAVES*32: slave i nonce at bits [i*32+31:i*32].
- `new_nonces` input SLAVES: one-cycle pulse per slave, nonce valid in the same cycle.
- `serial_busy` input 1: from `serial_transmit`; high while a word is being shifted out.
- `serial_send` output 1: one-cycle start pulse to `serial_transmit`.
- `golden_nonce` output 32: word to transmit; stable from the send pulse until the next send.
- `fifo_level` output FIFO_LOG2+1: current FIFO occupancy.
- `drop_count` output 16: saturating count of nonces lost to overwrite.

## Operation
- Per-slave capture: on `new_nonces[i]`, `hold[i]` <= nonce and `pend[i]` <= 1.
- Overwrite: a pulse on slave i while `pend[i]`=1 and i is not granted that cycle overwrites `hold[i]`. `drop_count` +1, saturating at 16'hFFFF.
- Arbiter: each cycle, search `pend` starting at pointer `rr` upward, mod SLAVES. The first set bit is the grant g, provided the FIFO can accept.
  - On grant: push `hold[g]`, clear `pend[g]`, and set `rr` <= (g+1) mod SLAVES.
  - At most one push per cycle.
- Grant and new pulse on the same slave in the same cycle: the old value is pushed, the new value is latched, `pend` stays 1, no drop.
- FIFO accepts when occupancy < 2^FIFO_LOG2, or when a pop happens in the same cycle (push and pop together while full is legal).
- A full FIFO with no pop means no grant; slaves stay pending. Losses occur only through overwrite.
- Drain FSM:
  - IDLE: if FIFO non-empty and !`serial_busy`: `golden_nonce` <= head, pop, `serial_send` <= 1 → SEND.
  - SEND: `serial_send` <= 0 → HOLD.
  - HOLD: hold for 2 cycles (gives `serial_busy` time to rise) → IDLE.
- Pointer arithmetic: FIFO read/write pointers are FIFO_LOG2 bits and wrap naturally. Occupancy is FIFO_LOG2+1 bits.

## Timing
- Reset values: `serial_send`=0, `golden_nonce`=0, `fifo_level`=0, `drop_count`=0. Internally `pend`=0, `rr`=0, FSM=IDLE, pointers 0. `hold` is don't-care.
- Latency, with an idle uplink and empty FIFO: pulse in cycle 0 → `pend` set in cycle 1 → pushed at the end of cycle 1 → `serial_send`=1 in cycle 3.
- Minimum spacing between `serial_send` pulses: 4 cycles (SEND + 2×HOLD + IDLE), and longer while `serial_busy`=1.
- `fifo_level` updates the cycle after a push or pop.
- Reset asserted mid-operation:
  - Next cycle: all state is as listed above, and queued and pending nonces are discarded.
  - A `serial_send` that was high drops the next cycle.
  - A word already inside `serial_transmit` is not aborted.

## Configuration
- `NONCE_DEDUP_EN` defined:
  - A register `last_push` (reset 0, plus a valid bit cleared at reset) records the last pushed word.
  - A granted `hold[g]` equal to `last_push` while valid is discarded: `pend[g]` is cleared, no push, `rr` advances, and `drop_count` is unchanged.
  - This suppresses duplicate reports, e.g. the same nonce from two slaves after work overlap.
- Undefined: every granted nonce is pushed; no comparator and no `last_push` register.

## Test plan
- Single nonce: `new_nonces`=2'b01 with 32'hDEADBEEF in cycle 0, `serial_busy`=0 → `serial_send`=1 in cycle 3 with `golden_nonce`=32'hDEADBEEF, `fifo_level` back to 0.
- Simultaneous pulses: slaves 0 and 1 pulse together (32'h11111111, 32'h22222222), `rr`=0 → transmitted in order 11111111 then 22222222. Repeat with `rr`=1 → order reversed.
- Back-pressure: hold `serial_busy`=1 and inject 9 nonces on alternating slaves with FIFO_LOG2=3 → `fifo_level`=8, one nonce held pending, `drop_count`=0. Release busy → all 9 sent in FIFO order.
- Overwrite: FIFO full with busy=1, slave 0 pulses 32'hA then 32'hB → `drop_count`=1 and 32'hB is eventually sent, 32'hA never.
- Reset mid-drain: reset for one cycle with `fifo_level`=5 → next cycle `fifo_level`=0, `serial_send`=0, `golden_nonce`=0, no further sends.
- With `NONCE_DEDUP_EN`: both slaves report 32'hCAFEF00D → exactly one `serial_send`, and `drop_count` stays 0. Without the macro, two sends.
